// File: rtl/bram36_stream_writer_256_64.sv
// Stream-to-BRAM loader: writes a valid/ready burst of words sequentially into a
// 256x64 block RAM from a programmable start address, with a 1-cycle registered read port.
module bram36_stream_writer_256_64 #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_data_i,
  input  logic              in_last_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   wr_count_o,
  output logic              overflow_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               we_s;
  logic [WIDTH-1:0]   rd_data_q;

  (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];

  // Next-state, pointer/count update and registered-flag decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ptr_d   = start_addr_i;
          cnt_d   = {CNT_W{1'b0}};
          ovf_d   = 1'b0;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // in_ready is high for the whole of WRITE, so in_valid alone accepts a beat.
        if (in_valid_i) begin
          we_s  = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (in_last_i) begin
            state_d = ST_DONE;
          end else if (cnt_q == CNT_W'(DEPTH - 1)) begin
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // Control state and registered status outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= {ADDR_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // RAM write port; contents are never cleared, and a beat coinciding with reset is dropped.
  always_ff @(posedge clock_i) begin
    if (we_s && !reset_i) begin
      mem_q[ptr_q] <= in_data_i;
    end
  end

  // Registered read port; same-address read during a write returns the old word.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_data_q <= {WIDTH{1'b0}};
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign in_ready_o = in_ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_count_o = cnt_q;
  assign overflow_o = ovf_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_bram36_stream_writer_256_64.sv
// Self-checking bench for bram36_stream_writer_256_64: vector table for the basic burst,
// hand sequences for wrap, overflow, read-during-write, mid-burst reset and ignored start.
module tb_bram36_stream_writer_256_64;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [7:0]  start_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] in_data_i;
  logic        in_last_i;
  logic        busy_o;
  logic        done_o;
  logic [8:0]  wr_count_o;
  logic        overflow_o;
  logic [7:0]  rd_addr_i;
  logic [63:0] rd_data_o;

  always #5 clk = ~clk;

  bram36_stream_writer_256_64 dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .wr_count_o   (wr_count_o),
    .overflow_o   (overflow_o),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t        vecs [8];
  logic [63:0] exp_mem [256];
  logic [7:0]  ptr_m;
  logic [63:0] sb_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] a);
    start_i      = 1'b1;
    start_addr_i = a;
    ptr_m        = a;
    step();
    start_i      = 1'b0;
  endtask

  // One accepted beat: in_ready must already be high before the edge.
  task automatic beat(input logic [63:0] d, input logic l);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = l;
    chk("in_ready_beat", 64'(in_ready_o), 64'd1);
    exp_mem[ptr_m] = d;
    ptr_m = ptr_m + 8'd1;
    step();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic rd_check(input logic [7:0] a);
    rd_addr_i = a;
    sb_q.push_back(exp_mem[a]);
    step();
    chk("rd_data", rd_data_o, sb_q.pop_front());
  endtask

  task automatic chk_done(input logic [8:0] cnt, input logic ovf);
    chk("done_pulse", 64'(done_o), 64'd1);
    chk("busy_done", 64'(busy_o), 64'd1);
    chk("ready_done", 64'(in_ready_o), 64'd0);
    chk("wr_count", 64'(wr_count_o), 64'(cnt));
    chk("overflow", 64'(overflow_o), 64'(ovf));
  endtask

  logic [63:0] wrap_d [4];
  logic        pat [6];

  initial begin
    vecs[0] = '{64'h44881112_3100C1A1, 1'b0, 9'd1};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 1'b0, 9'd2};
    vecs[2] = '{64'hFFFF_0000_FFFF_0000, 1'b0, 9'd3};
    vecs[3] = '{64'h0000_0000_0000_0001, 1'b0, 9'd4};
    vecs[4] = '{64'h8000_0000_0000_0000, 1'b0, 9'd5};
    vecs[5] = '{64'hA5A5_5A5A_C3C3_3C3C, 1'b0, 9'd6};
    vecs[6] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b0, 9'd7};
    vecs[7] = '{64'h13874949_28924428, 1'b1, 9'd8};
    wrap_d[0] = 64'h1111_2222_3333_4444;
    wrap_d[1] = 64'h5555_6666_7777_8888;
    wrap_d[2] = 64'h9999_AAAA_BBBB_CCCC;
    wrap_d[3] = 64'hDDDD_EEEE_FFFF_0000;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
    pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

    reset_i = 1'b1; start_i = 1'b0; start_addr_i = 8'd0; in_valid_i = 1'b0;
    in_data_i = 64'd0; in_last_i = 1'b0; rd_addr_i = 8'd0; ptr_m = 8'd0;
    step();
    step();
    chk("rst_ready", 64'(in_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_count", 64'(wr_count_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_rd", rd_data_o, 64'd0);
    reset_i = 1'b0;
    step();
    chk("idle_ready", 64'(in_ready_o), 64'd0);

    // Basic 8-beat burst from the vector table.
    do_start(8'h00);
    chk("write_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < 8; i++) begin
      beat(vecs[i].data, vecs[i].last);
      chk("tbl_count", 64'(wr_count_o), 64'(vecs[i].exp_cnt));
    end
    chk_done(9'd8, 1'b0);
    step();
    chk("idle_done", 64'(done_o), 64'd0);
    chk("idle_busy", 64'(busy_o), 64'd0);
    for (int a = 0; a < 8; a++) rd_check(8'(a));

    // Wrap-around burst with in_valid gaps.
    do_start(8'hFE);
    begin
      int k = 0;
      for (int c = 0; c < 6; c++) begin
        chk("wrap_ready", 64'(in_ready_o), 64'd1);
        in_valid_i = pat[c];
        in_data_i  = pat[c] ? wrap_d[k] : 64'hBAD0_BAD0_BAD0_BAD0;
        in_last_i  = pat[c] && (k == 3);
        if (pat[c]) begin
          exp_mem[ptr_m] = wrap_d[k];
          ptr_m = ptr_m + 8'd1;
          k++;
        end
        step();
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
    end
    chk_done(9'd4, 1'b0);
    step();
    rd_check(8'hFE); rd_check(8'hFF); rd_check(8'h00); rd_check(8'h01); rd_check(8'h02);

    // 256 beats without in_last: overflow, and the extra beat is dropped.
    do_start(8'h00);
    for (int i = 0; i < 256; i++) beat({32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)}, 1'b0);
    chk_done(9'd256, 1'b1);
    in_valid_i = 1'b1;
    in_data_i  = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    chk("ovf_count_hold", 64'(wr_count_o), 64'd256);
    chk("ovf_done_clr", 64'(done_o), 64'd0);
    step();
    in_valid_i = 1'b0;
    rd_check(8'h00); rd_check(8'hFF);

    // in_last on the 256th beat: no overflow.
    do_start(8'h00);
    chk("start_clr_ovf", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 256; i++) beat({32'hB0B0_0000 + 32'(i), ~(32'h0 + 32'(i))}, i == 255);
    chk_done(9'd256, 1'b0);
    step();
    rd_check(8'h80);

    // Read-during-write at address 5: old word first, new word next.
    do_start(8'h00);
    for (int i = 0; i < 8; i++) beat(64'd0, i == 7);
    step();
    rd_addr_i = 8'd5;
    do_start(8'h00);
    for (int i = 0; i < 5; i++) beat(64'hF0 + 64'(i), 1'b0);
    beat(64'hAD127839_139A12E5, 1'b1);
    chk("rdw_old", rd_data_o, 64'd0);
    step();
    chk("rdw_new", rd_data_o, 64'hAD127839_139A12E5);

    // Reset after 3 of 6 beats.
    do_start(8'h00);
    beat(64'h7777_0000_0000_0000, 1'b0);
    beat(64'h7777_0000_0000_0001, 1'b0);
    beat(64'h7777_0000_0000_0002, 1'b0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("mid_busy", 64'(busy_o), 64'd0);
    chk("mid_ready", 64'(in_ready_o), 64'd0);
    chk("mid_count", 64'(wr_count_o), 64'd0);
    chk("mid_done", 64'(done_o), 64'd0);
    chk("mid_rd", rd_data_o, 64'd0);
    step();
    chk("mid_done_after", 64'(done_o), 64'd0);
    for (int a = 0; a < 4; a++) rd_check(8'(a));

    // start during WRITE and during DONE is ignored.
    do_start(8'h10);
    beat(64'h0E0E_0000_0000_0010, 1'b0);
    start_i = 1'b1; start_addr_i = 8'h80;
    beat(64'h0E0E_0000_0000_0011, 1'b0);
    start_i = 1'b0;
    chk("ign_count_mid", 64'(wr_count_o), 64'd2);
    beat(64'h0E0E_0000_0000_0012, 1'b0);
    beat(64'h0E0E_0000_0000_0013, 1'b1);
    chk_done(9'd4, 1'b0);
    start_i = 1'b1; start_addr_i = 8'h80;
    step();
    start_i = 1'b0;
    chk("ign_busy", 64'(busy_o), 64'd0);
    chk("ign_count", 64'(wr_count_o), 64'd4);
    step();
    chk("ign_idle_ready", 64'(in_ready_o), 64'd0);
    for (int a = 16; a < 20; a++) rd_check(8'(a));
    rd_check(8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram36_stream_writer_256_64.md
Name: bram36_stream_writer_256_64

Overview:
Write-side counterpart to the team's behavioural 256x64 block ROMs. The block accepts a valid/ready stream of 64-bit words and writes them sequentially into an inferred 256x64 block RAM (ram_style = "block"), starting at a programmable address. It exposes a registered read port with the same 1-cycle latency as the ROMs, so a loaded table can be read by the same downstream logic.

Parameters:
DEPTH, 256, number of words; must be a power of two.
WIDTH, 64, data word width in bits.
ADDR_W, 8, address width; equals log2(DEPTH).

Ports:
clock  input  1  single clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse; begins a write burst when the block is idle
start_addr  input  ADDR_W  first write address, sampled on an accepted start
in_valid  input  1  stream word present
in_ready  output  1  block accepts a word this cycle
in_data  input  WIDTH  stream word
in_last  input  1  marks the final word of the burst
busy  output  1  high while in WRITE or DONE
done  output  1  1-cycle pulse at the end of a burst
wr_count  output  ADDR_W+1  words accepted in the current or last burst (0..DEPTH)
overflow  output  1  sticky; burst hit DEPTH words without in_last
rd_addr  input  ADDR_W  read address
rd_data  output  WIDTH  registered read data

Behaviour:
- Reset (synchronous, active-high): state=IDLE; in_ready=0, busy=0, done=0, wr_count=0, overflow=0, rd_data=0; write pointer=0. RAM contents are not cleared and are undefined until written.
- IDLE: in_ready=0. start=1 samples start_addr into ptr, clears wr_count and overflow, and moves to WRITE on the next cycle.
- WRITE: in_ready=1, busy=1. A beat is accepted when in_valid && in_ready. On an accepted beat:
  - mem[ptr] <= in_data
  - ptr <= ptr+1, wrapping DEPTH-1 -> 0
  - wr_count <= wr_count+1
- Leaving WRITE:
  - An accepted beat with in_last=1 goes to DONE.
  - An accepted beat that makes wr_count reach DEPTH with in_last=0 sets overflow=1 and goes to DONE.
  - When in_last=1 coincides with the DEPTH-th beat, overflow stays 0.
- DONE: one cycle. in_ready=0, done=1, busy=1. Then return to IDLE.
- start is ignored outside IDLE. in_valid is ignored while in_ready=0, and no write occurs.
- Beats are accepted back-to-back, one per cycle, with no bubbles. in_valid low stalls the burst indefinitely.
- wr_count and overflow hold their values after DONE until the next accepted start.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, giving 1-cycle latency.
  - Reads operate in every state.
  - Read-during-write to the same address is read-first: rd_data shows the old contents, and the new word is visible on the following read.
- Reset mid-burst: on the next cycle the block is in IDLE with all outputs at reset values. Words already written remain in the RAM. The partial burst is not reported via done.
- Wrap-around: with start_addr=8'hFE, a 4-word burst writes addresses FE, FF, 00, 01.

Test Plan:
- Reset, then start with start_addr=0 and 8 back-to-back beats of 64'h44881112_3100C1A1 .. 64'h13874949_28924428, in_last on the 8th beat -> wr_count=8, done pulses 1 cycle after the 8th beat, overflow=0; reading rd_addr=0..7 returns each word 1 cycle after its address is applied.
- start_addr=8'hFE, 4-word burst with in_valid toggling 1,0,1,1,0,1 -> exactly 4 writes to FE, FF, 00, 01; wr_count=4; in_ready stays 1 throughout WRITE.
- start_addr=0, 256 beats with in_last never asserted -> after the 256th beat overflow=1, done=1, in_ready=0; a 257th in_valid is not written (address 0 keeps beat 0 data).
- Read-during-write: rd_addr=5 held while beat 5 writes 64'hAD127839_139A12E5 over prior 0 -> rd_data=0 the next cycle, then 64'hAD127839_139A12E5 the cycle after.
- Assert reset after 3 of 6 beats -> next cycle busy=0, in_ready=0, wr_count=0, no done pulse; addresses 0..2 still hold the written data.
- Assert start during WRITE and during DONE -> ignored: ptr and wr_count are not reset, and the burst completes normally.
